// File: rtl/hazard_ctrl_if.sv
// Hazard-control signal bundle between the pipeline datapath and hazard_ctrl.
interface hazard_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_Rt_i;
  logic [4:0]  IFID_Rs_i;
  logic [4:0]  IFID_Rt_i;
  logic        Branch_i;
  logic        MemStall_i;
  logic        PCWrite_o;
  logic        PCSrc_o;
  logic        IFIDWrite_o;
  logic        IFIDFlush_o;
  logic        IDEXBubble_o;
  logic        PipeHold_o;
  logic        Timeout_o;
  logic [15:0] StallCnt_o;
  logic [15:0] FlushCnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i, MemStall_i,
    input  PCWrite_o, PCSrc_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeHold_o,
    input  Timeout_o, StallCnt_o, FlushCnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i, Branch_i, MemStall_i,
    output PCWrite_o, PCSrc_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeHold_o,
    output Timeout_o, StallCnt_o, FlushCnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze, branch flush,
// memory-wait watchdog and saturating stall/flush event counters.
//   state    | meaning
//   RUN      | normal issue; load-use and branches evaluated
//   LU_STALL | bubble inserted last cycle; load-use ignored, pending flush taken
//   MEM_WAIT | data memory busy; whole pipeline frozen, branches remembered
module hazard_ctrl (
  input  logic         Clock_i,
  input  logic         Reset_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t      state;
  logic        flush_pend;
  logic [7:0]  wait_cnt;
  logic        timeout_q;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic load_use;
  logic flush_take;
  logic wait_hit;
  logic pc_write;
  logic pc_src;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic pipe_hold;

  always_comb begin
    load_use     = hz.IDEX_MemRead_i && (hz.IDEX_Rt_i != 5'd0) &&
                   ((hz.IDEX_Rt_i == hz.IFID_Rs_i) || (hz.IDEX_Rt_i == hz.IFID_Rt_i));
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pc_src       = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    flush_take   = 1'b0;
    if (Reset_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hz.MemStall_i) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if ((state == RUN) && load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (hz.Branch_i || flush_pend) begin
      pc_src      = 1'b1;
      if_id_flush = 1'b1;
      flush_take  = 1'b1;
    end
    // wait_cnt becomes 255 at the end of this cycle while memory is still busy
    wait_hit = !Reset_i && hz.MemStall_i && (state == MEM_WAIT) && (wait_cnt == 8'd254);
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      wait_cnt   <= 8'd0;
      timeout_q  <= 1'b0;
      stall_cnt  <= 16'd0;
      flush_cnt  <= 16'd0;
    end else begin
      if (!pc_write && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_take && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
      if (wait_hit)
        timeout_q <= 1'b1;

      if (flush_take)
        flush_pend <= 1'b0;
      else if (hz.Branch_i && (hz.MemStall_i || ((state == RUN) && load_use)))
        flush_pend <= 1'b1;

      if (hz.MemStall_i) begin
        state <= MEM_WAIT;
        if (state != MEM_WAIT)
          wait_cnt <= 8'd0;
        else if (wait_cnt != 8'hFF)
          wait_cnt <= wait_cnt + 8'd1;
      end else if ((state == RUN) && load_use) begin
        state <= LU_STALL;
      end else begin
        state <= RUN;
      end
    end
  end

  assign hz.PCWrite_o    = pc_write;
  assign hz.PCSrc_o      = pc_src;
  assign hz.IFIDWrite_o  = if_id_write;
  assign hz.IFIDFlush_o  = if_id_flush;
  assign hz.IDEXBubble_o = id_ex_bubble;
  assign hz.PipeHold_o   = pipe_hold;
  assign hz.Timeout_o    = timeout_q | wait_hit;
  assign hz.StallCnt_o   = stall_cnt;
  assign hz.FlushCnt_o   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .Clock_i (clk),
    .Reset_i (rst),
    .hz      (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control vector order: {PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold}
  localparam logic [5:0] C_DEF  = 6'b101000;
  localparam logic [5:0] C_RST  = 6'b000110;
  localparam logic [5:0] C_HOLD = 6'b000001;
  localparam logic [5:0] C_BUB  = 6'b000010;
  localparam logic [5:0] C_FL   = 6'b111100;

  int tests_run = 0;
  int tests_failed = 0;

  // model: what the previous cycle did, plus the architecturally visible registers
  bit          m_prev_bub = 1'b0;
  bit          m_prev_frz = 1'b0;
  bit          m_pend = 1'b0;
  int          m_run = 0;
  bit          m_to = 1'b0;
  logic [15:0] m_sc = 16'd0;
  logic [15:0] m_fc = 16'd0;

  logic [5:0]  obs_ctrl;
  logic        obs_to;
  logic [15:0] obs_sc;
  logic [15:0] obs_fc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit br, input bit ms);
    logic [5:0]  e_ctrl;
    bit          e_to, lu;
    bit          n_prev_bub, n_prev_frz, n_pend, n_to;
    int          n_run;
    logic [15:0] n_sc, n_fc;
    rst               = r;
    hz.IDEX_MemRead_i = mr;
    hz.IDEX_Rt_i      = xrt;
    hz.IFID_Rs_i      = rs;
    hz.IFID_Rt_i      = rt;
    hz.Branch_i       = br;
    hz.MemStall_i     = ms;
    @(negedge clk);
    lu = mr && (xrt != 5'd0) && (xrt == rs || xrt == rt);
    n_fc = m_fc;
    if (r) begin
      e_ctrl = C_RST; e_to = m_to;
      n_prev_bub = 0; n_prev_frz = 0; n_pend = 0; n_run = 0; n_to = 0;
      n_fc = 16'd0;
    end else if (ms) begin
      e_ctrl = C_HOLD;
      n_run = m_run + 1;
      e_to = m_to || (n_run >= 256);
      n_to = e_to;
      n_pend = m_pend || br;
      n_prev_frz = 1; n_prev_bub = 0;
    end else begin
      n_run = 0; n_prev_frz = 0; e_to = m_to; n_to = m_to;
      if (lu && !m_prev_bub && !m_prev_frz) begin
        e_ctrl = C_BUB; n_pend = m_pend || br; n_prev_bub = 1;
      end else begin
        n_prev_bub = 0;
        if (br || m_pend) begin
          e_ctrl = C_FL; n_fc = sat_inc(m_fc); n_pend = 0;
        end else begin
          e_ctrl = C_DEF; n_pend = m_pend;
        end
      end
    end
    n_sc = r ? 16'd0 : (e_ctrl[5] ? m_sc : sat_inc(m_sc));

    obs_ctrl = {hz.PCWrite_o, hz.PCSrc_o, hz.IFIDWrite_o, hz.IFIDFlush_o,
                hz.IDEXBubble_o, hz.PipeHold_o};
    obs_to = hz.Timeout_o;
    obs_sc = hz.StallCnt_o;
    obs_fc = hz.FlushCnt_o;
    chk("ctrl", {26'd0, obs_ctrl}, {26'd0, e_ctrl});
    chk("timeout", {31'd0, obs_to}, {31'd0, e_to});
    chk("stall_cnt", {16'd0, obs_sc}, {16'd0, m_sc});
    chk("flush_cnt", {16'd0, obs_fc}, {16'd0, m_fc});

    m_prev_bub = n_prev_bub; m_prev_frz = n_prev_frz; m_pend = n_pend;
    m_run = n_run; m_to = n_to; m_sc = n_sc; m_fc = n_fc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit br);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, br, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    hz.IDEX_MemRead_i = 1'b0;
    hz.IDEX_Rt_i = 5'd0;
    hz.IFID_Rs_i = 5'd0;
    hz.IFID_Rt_i = 5'd0;
    hz.Branch_i = 1'b0;
    hz.MemStall_i = 1'b0;
    @(posedge clk);
    #1;

    do_reset();
    chk("rst_ctrl", {26'd0, obs_ctrl}, {26'd0, C_RST});
    idle(1'b0);
    chk("post_rst_def", {26'd0, obs_ctrl}, {26'd0, C_DEF});

    // load-use on Rs
    cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    chk("lu_bubble", {26'd0, obs_ctrl}, {26'd0, C_BUB});
    idle(1'b0);
    chk("lu_next_def", {26'd0, obs_ctrl}, {26'd0, C_DEF});
    chk("lu_stallcnt", {16'd0, obs_sc}, 32'd1);

    // load into r0 never stalls
    cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("r0_ctrl", {26'd0, obs_ctrl}, {26'd0, C_DEF});
    idle(1'b0);
    chk("r0_stallcnt", {16'd0, obs_sc}, 32'd1);

    idle(1'b1);
    chk("br_flush", {26'd0, obs_ctrl}, {26'd0, C_FL});
    idle(1'b0);
    chk("br_fcnt", {16'd0, obs_fc}, 32'd1);

    // memory stall with a branch seen mid-stall
    do_reset();
    idle(1'b0);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("ms_hold", {26'd0, obs_ctrl}, {26'd0, C_HOLD});
    idle(1'b0);
    chk("ms_flush", {26'd0, obs_ctrl}, {26'd0, C_FL});
    chk("ms_stallcnt", {16'd0, obs_sc}, 32'd3);
    idle(1'b0);
    chk("ms_fcnt", {16'd0, obs_fc}, 32'd1);
    chk("ms_after_def", {26'd0, obs_ctrl}, {26'd0, C_DEF});

    // load-use and branch together: stall first, flush next
    do_reset();
    idle(1'b0);
    cycle(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    chk("lub_stall", {26'd0, obs_ctrl}, {26'd0, C_BUB});
    cycle(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
    chk("lub_flush", {26'd0, obs_ctrl}, {26'd0, C_FL});

    // watchdog
    do_reset();
    idle(1'b0);
    for (int i = 1; i <= 300; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      if (i == 255) chk("to_before", {31'd0, obs_to}, 32'd0);
      if (i == 256) chk("to_set", {31'd0, obs_to}, 32'd1);
    end
    idle(1'b0);
    chk("to_sticky", {31'd0, obs_to}, 32'd1);
    chk("to_release_def", {26'd0, obs_ctrl}, {26'd0, C_DEF});
    do_reset();
    idle(1'b0);
    chk("rst_to_clear", {31'd0, obs_to}, 32'd0);
    chk("rst_sc_clear", {16'd0, obs_sc}, 32'd0);

    // reset during memory wait drops the pending flush
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    do_reset();
    idle(1'b0);
    chk("rst_mw_noflush", {26'd0, obs_ctrl}, {26'd0, C_DEF});
    chk("rst_mw_fcnt", {16'd0, obs_fc}, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
